// File: rtl/mips_cpu_run_monitor_if.sv
// Bus bundle between the run monitor and whatever drives it (host/bench side)
// plus the core status signals it observes.
//   slave  : the monitor -- takes start/expected_v0/core status, drives core
//            control and the result registers.
//   master : host side -- the mirror image of slave.
interface mips_cpu_run_monitor_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [DATA_W-1:0] expected_v0;
  logic              cpu_active;
  logic [DATA_W-1:0] cpu_register_v0;
  logic              cpu_reset;
  logic              cpu_clk_enable;
  logic [CNT_W-1:0]  cycle_count;
  logic [15:0]       stall_count;
  logic              done;
  logic              pass;
  logic              timeout;
  logic              active_err;

  modport master (
    output start, expected_v0, cpu_active, cpu_register_v0,
    input  cpu_reset, cpu_clk_enable, cycle_count, stall_count,
           done, pass, timeout, active_err
  );

  modport slave (
    input  start, expected_v0, cpu_active, cpu_register_v0,
    output cpu_reset, cpu_clk_enable, cycle_count, stall_count,
           done, pass, timeout, active_err
  );
endinterface

// File: rtl/mips_cpu_run_monitor.sv
// Run controller/checker for one Harvard MIPS core.
// Holds the core in reset, releases it with clk_enable, waits for cpu_active
// to rise and then fall, counts enabled RUN cycles, enforces a timeout and
// compares register_v0 against the expected value latched at start.
//
// Ports:
//   clk    : single clock, all logic on posedge
//   reset  : asynchronous, active-high
//   bus    : mips_cpu_run_monitor_if.slave
//            in : start, expected_v0, cpu_active, cpu_register_v0
//            out: cpu_reset, cpu_clk_enable, cycle_count, stall_count,
//                 done, pass, timeout, active_err (all registered)
//
// Build option: define STALL_INJECT_EN to add an LFSR that randomly drops
// cpu_clk_enable during RUN and counts those stall cycles; without it
// cpu_clk_enable stays high for the whole run and stall_count reads 0.
//
// state   | meaning
// IDLE    | core held in reset, waiting for start
// RST_CPU | core reset held for RESET_CYCLES cycles
// ARM     | core released, waiting up to ACTIVE_WAIT cycles for cpu_active
// RUN     | core running, counting cycles until halt or timeout
// DONE    | result frozen, core stopped but out of reset (state readable)
module mips_cpu_run_monitor #(
  parameter int          DATA_W         = 32,
  parameter int          CNT_W          = 32,
  parameter int          TIMEOUT_CYCLES = 10000,
  parameter int          RESET_CYCLES   = 1,
  parameter int          ACTIVE_WAIT    = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic                   clk,
  input logic                   reset,
  mips_cpu_run_monitor_if.slave bus
);

  if (RESET_CYCLES < 1 || ACTIVE_WAIT < 1 || LFSR_SEED == 16'h0) begin : g_bad_params
    $error("mips_cpu_run_monitor: RESET_CYCLES/ACTIVE_WAIT must be >= 1, LFSR_SEED nonzero");
  end

  localparam int TMR_MAX = (RESET_CYCLES > ACTIVE_WAIT) ? RESET_CYCLES : ACTIVE_WAIT;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] ARM_LOAD = TMR_W'(ACTIVE_WAIT - 1);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, RST_CPU, ARM, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [TMR_W-1:0]  tmr;
  logic [DATA_W-1:0] exp_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [CNT_W-1:0]  cyc_inc;
  logic              done_q, pass_q, tmo_q, aerr_q;
  logic              cpu_rst_q, cpu_en_q;
  logic              start_acc, halt, tmo_hit, arm_err;
  logic              stall_now;   // current RUN cycle has the core clock gated
  logic              stall_nx;    // next cycle will be a stall if it is in RUN

  assign cyc_inc = (cyc_q == {CNT_W{1'b1}}) ? cyc_q : cyc_q + 1'b1;

`ifdef STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_nx;
  logic [15:0] stall_q;

  // Fibonacci LFSR, taps 16,14,13,11 (shift right, feedback into bit 15).
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  always_comb begin
    lfsr_nx = lfsr_q;
    if (start_acc)
      lfsr_nx = LFSR_SEED;
    else if (state == RUN)
      lfsr_nx = lfsr_step(lfsr_q);
  end

  // The LFSR value held during a RUN cycle decides whether that cycle stalls;
  // the enable register is computed from the value the next cycle will hold.
  assign stall_now = (state == RUN) && (lfsr_q[3:0] == 4'h0);
  assign stall_nx  = (lfsr_nx[3:0] == 4'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= LFSR_SEED;
      stall_q <= '0;
    end else begin
      lfsr_q <= lfsr_nx;
      if (start_acc)
        stall_q <= '0;
      else if (stall_now && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_count = stall_q;
`else
  assign stall_now       = 1'b0;
  assign stall_nx        = 1'b0;
  assign bus.stall_count = 16'h0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_acc = 1'b0;
    halt      = 1'b0;
    tmo_hit   = 1'b0;
    arm_err   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_nx  = RST_CPU;
        end
      end
      RST_CPU: begin
        if (tmr == '0)
          state_nx = ARM;
      end
      ARM: begin
        if (bus.cpu_active) begin
          state_nx = RUN;
        end else if (tmr == '0) begin
          arm_err  = 1'b1;
          state_nx = DONE;
        end
      end
      RUN: begin
        // Halt is checked before the limit so a halt landing on the limit
        // cycle is reported as a normal finish.
        if (!stall_now) begin
          if (!bus.cpu_active) begin
            halt     = 1'b1;
            state_nx = DONE;
          end else if (cyc_inc >= TMO_LIM) begin
            tmo_hit  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Down-counter shared by RST_CPU and ARM, reloaded on entry to each.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr <= '0;
    end else if (state_nx == RST_CPU && state != RST_CPU) begin
      tmr <= RST_LOAD;
    end else if (state_nx == ARM && state != ARM) begin
      tmr <= ARM_LOAD;
    end else if (tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q     <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
      aerr_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
    end else begin
      cpu_rst_q <= (state_nx == IDLE) || (state_nx == RST_CPU);
      cpu_en_q  <= (state_nx == ARM) || (state_nx == RUN && !stall_nx);
      if (start_acc) begin
        exp_q  <= bus.expected_v0;
        cyc_q  <= '0;
        done_q <= 1'b0;
        pass_q <= 1'b0;
        tmo_q  <= 1'b0;
        aerr_q <= 1'b0;
      end else begin
        if (state == RUN && !stall_now)
          cyc_q <= cyc_inc;
        if (halt) begin
          done_q <= 1'b1;
          pass_q <= (bus.cpu_register_v0 == exp_q);
        end
        if (tmo_hit) begin
          done_q <= 1'b1;
          tmo_q  <= 1'b1;
        end
        if (arm_err) begin
          done_q <= 1'b1;
          aerr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cpu_reset      = cpu_rst_q;
  assign bus.cpu_clk_enable = cpu_en_q;
  assign bus.cycle_count    = cyc_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.timeout        = tmo_q;
  assign bus.active_err     = aerr_q;

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
module tb_mips_cpu_run_monitor;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int RC = 3;
  localparam int AW = 4;
`ifdef STALL_INJECT_EN
  localparam int T  = 150;
`else
  localparam int T  = 50;
`endif
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mips_cpu_run_monitor_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  mips_cpu_run_monitor #(
    .DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYCLES(T), .RESET_CYCLES(RC),
    .ACTIVE_WAIT(AW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: stall cycles seen before `target` enabled RUN cycles, from the
  // LFSR definition (taps 16,14,13,11, seeded at start, one step per RUN cycle).
  function automatic int exp_stalls(input int target);
`ifdef STALL_INJECT_EN
    int unsigned l = SEED;
    int unsigned b;
    int en = 0;
    int st = 0;
    for (int guard = 0; guard < 50000 && en < target; guard++) begin
      if ((l & 15) == 0) st++;
      else en++;
      b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end
    return st;
`else
    return (target < 0) ? 1 : 0;
`endif
  endfunction

  task automatic start_and_reset_phase(input string tag, input logic [31:0] exp_v);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.expected_v0 = exp_v;
    bus.cpu_active = 1'b0;
    bus.cpu_register_v0 = $urandom;
    @(negedge clk);
    bus.start = 1'b0;
    bus.expected_v0 = $urandom;
    n = 0;
    while (bus.cpu_reset === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".rst_len"}, n, RC);
    chk({tag, ".arm_en"}, bus.cpu_clk_enable, 1'b1);
    chk({tag, ".flags_clr"}, {bus.done, bus.pass, bus.timeout, bus.active_err}, 4'b0);
    chk({tag, ".cnt_clr"}, bus.cycle_count, 0);
  endtask

  // a: ARM edges with cpu_active low before it rises; r: enabled RUN cycles
  // until the core drops cpu_active (halt); v0 presented on that cycle.
  task automatic do_run(input string tag, input int a, input int r,
                        input logic [31:0] exp_v, input logic [31:0] v0,
                        input bit poke_start);
    int n, en, tgt;
    bit exp_pass, exp_to;
    logic [31:0] cc;
    start_and_reset_phase(tag, exp_v);
    for (int i = 0; i < a; i++) begin
      bus.cpu_active = 1'b0;
      @(negedge clk);
    end
    bus.cpu_active = 1'b1;
    @(negedge clk);
    en = 0;
    n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      if (bus.cpu_clk_enable === 1'b1) en++;
      bus.cpu_active = (en < r);
      bus.cpu_register_v0 = (en >= r) ? v0 : $urandom;
      bus.start = poke_start && (en == 2);
      bus.expected_v0 = $urandom;
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    tgt      = (r <= T) ? r : T;
    exp_to   = (r > T);
    exp_pass = (r <= T) && (v0 == exp_v);
    chk({tag, ".done"}, bus.done, 1'b1);
    chk({tag, ".count"}, bus.cycle_count, tgt);
    chk({tag, ".pass"}, bus.pass, exp_pass);
    chk({tag, ".timeout"}, bus.timeout, exp_to);
    chk({tag, ".active_err"}, bus.active_err, 1'b0);
    chk({tag, ".en_off"}, bus.cpu_clk_enable, 1'b0);
    chk({tag, ".rst_off"}, bus.cpu_reset, 1'b0);
    chk({tag, ".stalls"}, bus.stall_count, exp_stalls(tgt));
    cc = bus.cycle_count;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_active = 1'($urandom);
      bus.cpu_register_v0 = $urandom;
      @(negedge clk);
    end
    chk({tag, ".frozen_cnt"}, bus.cycle_count, cc);
    chk({tag, ".frozen_flags"}, {bus.done, bus.pass, bus.timeout},
        {1'b1, exp_pass, exp_to});
  endtask

  task automatic do_active_err(input string tag);
    int n;
    start_and_reset_phase(tag, 32'h1234);
    bus.cpu_active = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({tag, ".arm_cycles"}, n, AW);
    chk({tag, ".flags"}, {bus.done, bus.pass, bus.timeout, bus.active_err}, 4'b1001);
    chk({tag, ".en_off"}, bus.cpu_clk_enable, 1'b0);
    chk({tag, ".count"}, bus.cycle_count, 0);
  endtask

  task automatic do_reset_midrun(input string tag);
    start_and_reset_phase(tag, 32'hCAFE);
    bus.cpu_active = 1'b1;
    for (int i = 0; i < 8; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    chk({tag, ".cpu_reset"}, bus.cpu_reset, 1'b1);
    chk({tag, ".en"}, bus.cpu_clk_enable, 1'b0);
    chk({tag, ".count"}, bus.cycle_count, 0);
    chk({tag, ".flags"}, {bus.done, bus.pass, bus.timeout, bus.active_err}, 4'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_active = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_rst"}, {bus.cpu_reset, bus.cpu_clk_enable, bus.done}, 3'b100);
  endtask

  initial begin
    int a, r;
    logic [31:0] e, v;
    bus.start = 1'b0;
    bus.expected_v0 = '0;
    bus.cpu_active = 1'b0;
    bus.cpu_register_v0 = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset.cpu_reset", bus.cpu_reset, 1'b1);
    chk("reset.en", bus.cpu_clk_enable, 1'b0);
    chk("reset.counts", {bus.cycle_count, bus.stall_count}, 0);
    chk("reset.flags", {bus.done, bus.pass, bus.timeout, bus.active_err}, 4'b0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle.hold", {bus.cpu_reset, bus.cpu_clk_enable, bus.done}, 3'b100);

    do_run("t1_match", 1, 20, 32'h5, 32'h5, 1'b0);
    do_run("t2_mismatch", 1, 20, 32'h5, 32'h6, 1'b0);
    do_run("t3_timeout", 0, 100000, 32'h7, 32'h7, 1'b0);
    do_active_err("t4_active_err");
    do_run("t5_halt_at_limit", 2, T, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    do_run("t5_one_before", 1, T - 1, 32'h42, 32'h43, 1'b0);
    do_run("t5_one_after", 0, T + 1, 32'h42, 32'h42, 1'b0);
    do_run("late_active", AW - 1, 1, 32'h9, 32'h9, 1'b0);
    do_reset_midrun("t5_reset");
`ifdef STALL_INJECT_EN
    do_run("t6_stall", 1, 100, 32'h5, 32'h5, 1'b0);
`endif
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(AW - 1, 0);
      r = $urandom_range(T + 5, 1);
      e = $urandom;
      v = ($urandom_range(1, 0) == 1) ? e : (e ^ (32'h1 << $urandom_range(31, 0)));
      do_run($sformatf("rand%0d", k), a, r, e, v, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
